border_tracker: RTL and testbench
=================================

Name: border_tracker

Overview:
- Parametrised successor of the per-router border detector in the NoC discovery phase.
- Merges bounding-box advertisements from NUM_PORTS neighbour channels into a registered min/max box. All channels valid in the same cycle are folded together.
- Declares completion on an expected-message count and then publishes the four edge-anchor coordinates (up/down/left/right) used by downstream routing setup.
- Sits beside the router control FSM and is driven by explicit start/clear pulses rather than a shared state bus.

Parameters:
NUM_PORTS, 4, number of neighbour input channels (N,E,S,W order, bit 0 = N)
FLIT_W, 64, flit width per channel
COORD_W, 3, width of one coordinate
XMIN_LSB, 23, LSB of x_min field in flit; y_min, x_max, y_max follow at successively lower COORD_W slices
MESH_X, 6, mesh width
MESH_Y, 6, mesh height
EXPECT_CNT, 2*(MESH_X+MESH_Y)-4, advertisements required for done
CNT_W, 6, message counter width
TIMEOUT_CYC, 255, idle cycles before forced done (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  pulse: begin or restart collection
clear  in  1  pulse: abandon and return to IDLE
my_x  in  COORD_W  own x coordinate
my_y  in  COORD_W  own y coordinate
in_valid  in  NUM_PORTS  per-channel advertisement valid
in_data  in  NUM_PORTS*FLIT_W  flattened flits, channel i at [i*FLIT_W +: FLIT_W]
x_min, y_min, x_max, y_max  out  COORD_W each  registered bounding box
busy  out  1  high in COLLECT
done  out  1  high in DONE
timed_out  out  1  DONE reached by timeout
up, down, left, right  out  2*COORD_W each  anchor {y,x}: x in [COORD_W-1:0], y above
msg_cnt  out  CNT_W  advertisements absorbed

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; every output and counter 0.
- States: IDLE, COLLECT, DONE.
- Precedence: reset > clear > start > normal operation.
- clear in any state: next state IDLE, all outputs 0.
- start in any state: bounds load {my_x, my_y, my_x, my_y}; msg_cnt = 0; anchors 0; timed_out 0; next state COLLECT. Inputs in the start cycle are ignored.
- COLLECT, each cycle:
  - Every valid channel is compared per field, independently of the others. New x_min = min(current, all valid fields); likewise y_min, x_max (max), y_max (max).
  - Ties keep the current value.
  - Updated bounds are visible the next cycle (1-cycle latency).
- msg_cnt += popcount(in_valid); saturates at 2^CNT_W-1 and never wraps.
- COLLECT->DONE when the updated msg_cnt >= EXPECT_CNT. That edge also registers:
  - up = {y_min', floor((x_min'+x_max')/2)}
  - down = {y_max', same x}
  - left = {floor((y_min'+y_max')/2), x_min'}
  - right = {same y, x_max'}
  - Primes denote the post-update bounds. Sums are computed at COORD_W+1 bits, then shifted right by 1.
  - done asserts the cycle after the threshold-crossing input.
- DONE: all outputs held; in_valid ignored; only start, clear or reset leave DONE.
- IDLE: in_valid ignored; outputs hold their last value; start required.
- A message with min field > max field is not validated; fields are folded as-is.

Optional Feature:
- Macro BORDER_TIMEOUT_EN.
- Defined:
  - Idle counter clears on start and on any cycle with in_valid != 0 in COLLECT; otherwise it increments in COLLECT.
  - When it reaches TIMEOUT_CYC, next state is DONE with anchors computed from current bounds and timed_out = 1.
  - If the count threshold and the timeout hit on the same edge, count wins and timed_out = 0.
- Undefined: no timer logic; timed_out tied 0.

Decomposition:
- Shared package/defines: state encoding, flit field LSB offsets, anchor packing macros, COORD_W default.
- One natural sub-module, bbox_merge: combinational NUM_PORTS-way min/max fold of the four fields against the current box. The top keeps the FSM, counters and registers.

Test Plan:
- Reset then start with my=(2,3); no valid for 10 cycles -> bounds (2,3,2,3), busy=1, done=0, msg_cnt=0.
- Same cycle: N carries (1,3,2,3), E carries (2,0,5,3) -> next cycle box (1,0,5,3), msg_cnt=2.
- 20 single-port messages whose union is (0,0,5,5) -> done on cycle after the 20th; up={0,2}, down={5,2}, left={2,0}, right={2,5}.
- Start asserted mid-COLLECT with in_valid=4'b1111 -> inputs dropped; box reloads own coordinate; msg_cnt=0.
- clear in DONE -> next cycle all outputs 0, IDLE; later in_valid pulses cause no change.
- With BORDER_TIMEOUT_EN and TIMEOUT_CYC=8: one message, then 8 idle cycles -> done=1, timed_out=1, anchors from the partial box; without the macro, busy remains 1.

Source files
------------

// File: rtl/border_tracker_pkg.sv
// Shared definitions for border_tracker: FSM encoding, flit field offsets and default widths.
// The optional idle timeout is enabled with the BORDER_TIMEOUT_EN macro.
package border_tracker_pkg;

  localparam int DEF_COORD_W  = 3;
  localparam int DEF_XMIN_LSB = 23;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Field LSBs, counted down from the x_min LSB in COORD_W steps.
  function automatic int field_lsb(input int xmin_lsb, input int coord_w, input int idx);
    return xmin_lsb - idx * coord_w;
  endfunction

endpackage

// File: rtl/border_tracker_bbox_merge.sv
// Combinational NUM_PORTS-way min/max fold of advertised boxes against the current box.
// Ties keep the current value; fields are folded as-is even when min > max.
module bbox_merge
  import border_tracker_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int FLIT_W    = 64,
  parameter int COORD_W   = DEF_COORD_W,
  parameter int XMIN_LSB  = DEF_XMIN_LSB
) (
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [NUM_PORTS*FLIT_W-1:0] in_data,
  input  logic [COORD_W-1:0]          cur_x_min,
  input  logic [COORD_W-1:0]          cur_y_min,
  input  logic [COORD_W-1:0]          cur_x_max,
  input  logic [COORD_W-1:0]          cur_y_max,
  output logic [COORD_W-1:0]          nxt_x_min,
  output logic [COORD_W-1:0]          nxt_y_min,
  output logic [COORD_W-1:0]          nxt_x_max,
  output logic [COORD_W-1:0]          nxt_y_max
);

  localparam int XMIN_OFF = field_lsb(XMIN_LSB, COORD_W, 0);
  localparam int YMIN_OFF = field_lsb(XMIN_LSB, COORD_W, 1);
  localparam int XMAX_OFF = field_lsb(XMIN_LSB, COORD_W, 2);
  localparam int YMAX_OFF = field_lsb(XMIN_LSB, COORD_W, 3);

  always_comb begin
    nxt_x_min = cur_x_min;
    nxt_y_min = cur_y_min;
    nxt_x_max = cur_x_max;
    nxt_y_max = cur_y_max;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (in_valid[i]) begin
        if (in_data[i*FLIT_W + XMIN_OFF +: COORD_W] < nxt_x_min)
          nxt_x_min = in_data[i*FLIT_W + XMIN_OFF +: COORD_W];
        if (in_data[i*FLIT_W + YMIN_OFF +: COORD_W] < nxt_y_min)
          nxt_y_min = in_data[i*FLIT_W + YMIN_OFF +: COORD_W];
        if (in_data[i*FLIT_W + XMAX_OFF +: COORD_W] > nxt_x_max)
          nxt_x_max = in_data[i*FLIT_W + XMAX_OFF +: COORD_W];
        if (in_data[i*FLIT_W + YMAX_OFF +: COORD_W] > nxt_y_max)
          nxt_y_max = in_data[i*FLIT_W + YMAX_OFF +: COORD_W];
      end
    end
  end

endmodule

// File: rtl/border_tracker.sv
// Collects neighbour bounding-box adverts into a registered box and publishes edge anchors on completion.
// Define BORDER_TIMEOUT_EN to add an idle timer that forces DONE after TIMEOUT_CYC quiet cycles.
module border_tracker
  import border_tracker_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int FLIT_W      = 64,
  parameter int COORD_W     = DEF_COORD_W,
  parameter int XMIN_LSB    = DEF_XMIN_LSB,
  parameter int MESH_X      = 6,
  parameter int MESH_Y      = 6,
  parameter int EXPECT_CNT  = 2*(MESH_X+MESH_Y)-4,
  parameter int CNT_W       = 6,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        clear,
  input  logic [COORD_W-1:0]          my_x,
  input  logic [COORD_W-1:0]          my_y,
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [NUM_PORTS*FLIT_W-1:0] in_data,
  output logic [COORD_W-1:0]          x_min,
  output logic [COORD_W-1:0]          y_min,
  output logic [COORD_W-1:0]          x_max,
  output logic [COORD_W-1:0]          y_max,
  output logic                        busy,
  output logic                        done,
  output logic                        timed_out,
  output logic [2*COORD_W-1:0]        up,
  output logic [2*COORD_W-1:0]        down,
  output logic [2*COORD_W-1:0]        left,
  output logic [2*COORD_W-1:0]        right,
  output logic [CNT_W-1:0]            msg_cnt,
  output logic [1:0]                  dbg_state
);

  localparam int PC_W  = $clog2(NUM_PORTS + 1);
  localparam int SUM_W = CNT_W + PC_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] EXPECT_C = CNT_W'(EXPECT_CNT);

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   x_min_q, x_min_d, y_min_q, y_min_d;
  logic [COORD_W-1:0]   x_max_q, x_max_d, y_max_q, y_max_d;
  logic [CNT_W-1:0]     msg_cnt_q, msg_cnt_d;
  logic [2*COORD_W-1:0] up_q, up_d, down_q, down_d, left_q, left_d, right_q, right_d;
  logic                 timed_out_q, timed_out_d;

  logic [COORD_W-1:0]   m_x_min, m_y_min, m_x_max, m_y_max;
  logic [PC_W-1:0]      pop;
  logic [SUM_W-1:0]     cnt_sum;
  logic [CNT_W-1:0]     cnt_sat;
  logic [COORD_W:0]     sum_x, sum_y;
  logic [COORD_W-1:0]   mid_x, mid_y;

  bbox_merge #(
    .NUM_PORTS (NUM_PORTS),
    .FLIT_W    (FLIT_W),
    .COORD_W   (COORD_W),
    .XMIN_LSB  (XMIN_LSB)
  ) u_merge (
    .in_valid  (in_valid),
    .in_data   (in_data),
    .cur_x_min (x_min_q),
    .cur_y_min (y_min_q),
    .cur_x_max (x_max_q),
    .cur_y_max (y_max_q),
    .nxt_x_min (m_x_min),
    .nxt_y_min (m_y_min),
    .nxt_x_max (m_x_max),
    .nxt_y_max (m_y_max)
  );

  // Saturating message count and midpoints of the post-merge box.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_PORTS; i++) pop = pop + PC_W'(in_valid[i]);
    cnt_sum = SUM_W'(msg_cnt_q) + SUM_W'(pop);
    cnt_sat = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    sum_x   = {1'b0, m_x_min} + {1'b0, m_x_max};
    sum_y   = {1'b0, m_y_min} + {1'b0, m_y_max};
    mid_x   = sum_x[COORD_W:1];
    mid_y   = sum_y[COORD_W:1];
  end

`ifdef BORDER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_q, idle_d, idle_nxt;
  logic              tmo_hit;

  always_comb begin
    idle_nxt = (|in_valid) ? '0 : idle_q + 1'b1;
    tmo_hit  = (idle_nxt == IDLE_W'(TIMEOUT_CYC));
    idle_d   = idle_q;
    if (clear || start)              idle_d = '0;
    else if (state_q == ST_COLLECT)  idle_d = idle_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  logic tmo_hit;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    x_min_d     = x_min_q;
    y_min_d     = y_min_q;
    x_max_d     = x_max_q;
    y_max_d     = y_max_q;
    msg_cnt_d   = msg_cnt_q;
    up_d        = up_q;
    down_d      = down_q;
    left_d      = left_q;
    right_d     = right_q;
    timed_out_d = timed_out_q;
    if (clear) begin
      state_d     = ST_IDLE;
      x_min_d     = '0;
      y_min_d     = '0;
      x_max_d     = '0;
      y_max_d     = '0;
      msg_cnt_d   = '0;
      up_d        = '0;
      down_d      = '0;
      left_d      = '0;
      right_d     = '0;
      timed_out_d = 1'b0;
    end else if (start) begin
      state_d     = ST_COLLECT;
      x_min_d     = my_x;
      y_min_d     = my_y;
      x_max_d     = my_x;
      y_max_d     = my_y;
      msg_cnt_d   = '0;
      up_d        = '0;
      down_d      = '0;
      left_d      = '0;
      right_d     = '0;
      timed_out_d = 1'b0;
    end else if (state_q == ST_COLLECT) begin
      x_min_d   = m_x_min;
      y_min_d   = m_y_min;
      x_max_d   = m_x_max;
      y_max_d   = m_y_max;
      msg_cnt_d = cnt_sat;
      // Count threshold takes priority over the idle timeout on the same edge.
      if (cnt_sat >= EXPECT_C || tmo_hit) begin
        state_d     = ST_DONE;
        up_d        = {m_y_min, mid_x};
        down_d      = {m_y_max, mid_x};
        left_d      = {mid_y, m_x_min};
        right_d     = {mid_y, m_x_max};
        timed_out_d = !(cnt_sat >= EXPECT_C);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      x_min_q     <= '0;
      y_min_q     <= '0;
      x_max_q     <= '0;
      y_max_q     <= '0;
      msg_cnt_q   <= '0;
      up_q        <= '0;
      down_q      <= '0;
      left_q      <= '0;
      right_q     <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_min_q     <= x_min_d;
      y_min_q     <= y_min_d;
      x_max_q     <= x_max_d;
      y_max_q     <= y_max_d;
      msg_cnt_q   <= msg_cnt_d;
      up_q        <= up_d;
      down_q      <= down_d;
      left_q      <= left_d;
      right_q     <= right_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign x_min     = x_min_q;
  assign y_min     = y_min_q;
  assign x_max     = x_max_q;
  assign y_max     = y_max_q;
  assign msg_cnt   = msg_cnt_q;
  assign up        = up_q;
  assign down      = down_q;
  assign left      = left_q;
  assign right     = right_q;
  assign timed_out = timed_out_q;
  assign busy      = (state_q == ST_COLLECT);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_border_tracker.sv
// Directed bench for border_tracker: reset, merge, threshold, restart, clear and idle timeout.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_border_tracker;

  localparam int NP = 4;
  localparam int FW = 64;
  localparam int CW = 3;

  logic              clk;
  logic              reset;
  logic              start;
  logic              clear;
  logic [CW-1:0]     my_x, my_y;
  logic [NP-1:0]     in_valid;
  logic [NP*FW-1:0]  in_data;
  logic [CW-1:0]     x_min, y_min, x_max, y_max;
  logic              busy, done, timed_out;
  logic [2*CW-1:0]   up, down, left, right;
  logic [5:0]        msg_cnt;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  border_tracker #(.TIMEOUT_CYC(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .clear     (clear),
    .my_x      (my_x),
    .my_y      (my_y),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .x_min     (x_min),
    .y_min     (y_min),
    .x_max     (x_max),
    .y_max     (y_max),
    .busy      (busy),
    .done      (done),
    .timed_out (timed_out),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .msg_cnt   (msg_cnt),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] mk_flit(input int xn, input int yn, input int xx, input int yx);
    logic [FW-1:0] f;
    f = '0;
    f[25:23] = xn[2:0];
    f[22:20] = yn[2:0];
    f[19:17] = xx[2:0];
    f[16:14] = yx[2:0];
    return f;
  endfunction

  // Driver tasks
  task automatic idle_inputs();
    start = 0; clear = 0; in_valid = '0; in_data = '0;
  endtask

  task automatic pulse_start();
    start = 1; step(); start = 0;
  endtask

  task automatic send_one(input int port, input int xn, input int yn, input int xx, input int yx);
    in_valid = '0;
    in_data = '0;
    in_valid[port] = 1'b1;
    in_data[port*FW +: FW] = mk_flit(xn, yn, xx, yx);
    step();
    in_valid = '0;
    in_data = '0;
  endtask

  task automatic check_box(input string name, input int exn, input int eyn, input int exx, input int eyx);
    checks++;
    if (x_min !== exn[CW-1:0] || y_min !== eyn[CW-1:0] || x_max !== exx[CW-1:0] || y_max !== eyx[CW-1:0]) begin
      errors++;
      $display("FAIL %s: box got (%0d,%0d,%0d,%0d) expected (%0d,%0d,%0d,%0d)",
               name, x_min, y_min, x_max, y_max, exn, eyn, exx, eyx);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    my_x = 3'd2; my_y = 3'd3;
    reset = 0;
    step(); step();
    reset = 1;
    checks++;
    if ({x_min, y_min, x_max, y_max, busy, done, timed_out, up, down, left, right, msg_cnt} !== '0) begin
      errors++;
      $display("FAIL reset: outputs got box=(%0d,%0d,%0d,%0d) busy=%0b done=%0b cnt=%0d expected all 0",
               x_min, y_min, x_max, y_max, busy, done, msg_cnt);
    end
  endtask

  task automatic test_start_idle();
    pulse_start();
    repeat (10) step();
    check_box("start_idle_box", 2, 3, 2, 3);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || msg_cnt !== 6'd0) begin
      errors++;
      $display("FAIL start_idle: busy=%0b done=%0b cnt=%0d expected busy=1 done=0 cnt=0", busy, done, msg_cnt);
    end
  endtask

  task automatic test_merge_two();
    in_valid = 4'b0011;
    in_data = '0;
    in_data[0*FW +: FW] = mk_flit(1, 3, 2, 3);
    in_data[1*FW +: FW] = mk_flit(2, 0, 5, 3);
    step();
    in_valid = '0;
    check_box("merge_two_box", 1, 0, 5, 3);
    checks++;
    if (msg_cnt !== 6'd2) begin
      errors++;
      $display("FAIL merge_two_cnt: got %0d expected 2", msg_cnt);
    end
  endtask

  task automatic test_threshold();
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      case (k)
        3:  send_one(k % NP, 0, 3, 2, 3);
        7:  send_one(k % NP, 2, 0, 2, 3);
        11: send_one(k % NP, 2, 3, 5, 3);
        15: send_one(k % NP, 2, 3, 2, 5);
        default: send_one(k % NP, 2, 3, 2, 3);
      endcase
      if (k == 18) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || msg_cnt !== 6'd19) begin
          errors++;
          $display("FAIL threshold_pre: done=%0b busy=%0b cnt=%0d expected done=0 busy=1 cnt=19", done, busy, msg_cnt);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || msg_cnt !== 6'd20 || timed_out !== 1'b0) begin
      errors++;
      $display("FAIL threshold_done: done=%0b busy=%0b cnt=%0d tmo=%0b expected 1,0,20,0", done, busy, msg_cnt, timed_out);
    end
    check_box("threshold_box", 0, 0, 5, 5);
    checks++;
    if (up !== 6'd2 || down !== 6'd42 || left !== 6'd16 || right !== 6'd21) begin
      errors++;
      $display("FAIL threshold_anchors: up=%0d down=%0d left=%0d right=%0d expected 2,42,16,21", up, down, left, right);
    end
  endtask

  task automatic test_done_hold();
    in_valid = 4'b1111;
    for (int i = 0; i < NP; i++) in_data[i*FW +: FW] = mk_flit(7, 7, 0, 0);
    step(); step();
    idle_inputs();
    check_box("done_hold_box", 0, 0, 5, 5);
    checks++;
    if (done !== 1'b1 || msg_cnt !== 6'd20 || up !== 6'd2) begin
      errors++;
      $display("FAIL done_hold: done=%0b cnt=%0d up=%0d expected 1,20,2", done, msg_cnt, up);
    end
  endtask

  task automatic test_clear();
    clear = 1; step(); clear = 0;
    checks++;
    if ({x_min, y_min, x_max, y_max, busy, done, timed_out, up, down, left, right, msg_cnt} !== '0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL clear: box=(%0d,%0d,%0d,%0d) done=%0b cnt=%0d up=%0d state=%0d expected all 0",
               x_min, y_min, x_max, y_max, done, msg_cnt, up, dbg_state);
    end
    send_one(0, 0, 0, 7, 7);
    send_one(2, 0, 0, 7, 7);
    checks++;
    if ({x_min, y_min, x_max, y_max, busy, done, msg_cnt} !== '0) begin
      errors++;
      $display("FAIL idle_ignore: box=(%0d,%0d,%0d,%0d) busy=%0b cnt=%0d expected all 0",
               x_min, y_min, x_max, y_max, busy, msg_cnt);
    end
  endtask

  task automatic test_restart();
    pulse_start();
    send_one(1, 0, 1, 4, 5);
    start = 1;
    in_valid = 4'b1111;
    for (int i = 0; i < NP; i++) in_data[i*FW +: FW] = mk_flit(0, 0, 7, 7);
    step();
    idle_inputs();
    check_box("restart_box", 2, 3, 2, 3);
    checks++;
    if (msg_cnt !== 6'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart: cnt=%0d busy=%0b expected 0,1", msg_cnt, busy);
    end
  endtask

  task automatic test_multi_cross();
    pulse_start();
    for (int c = 0; c < 4; c++) begin
      in_valid = 4'b1111;
      for (int i = 0; i < NP; i++) in_data[i*FW +: FW] = mk_flit(2, 3, 2, 3);
      step();
    end
    in_valid = 4'b0111; step();
    checks++;
    if (done !== 1'b0 || msg_cnt !== 6'd19) begin
      errors++;
      $display("FAIL multi_pre: done=%0b cnt=%0d expected 0,19", done, msg_cnt);
    end
    in_valid = 4'b1010;
    in_data[1*FW +: FW] = mk_flit(1, 1, 4, 6);
    step();
    idle_inputs();
    checks++;
    if (done !== 1'b1 || msg_cnt !== 6'd21) begin
      errors++;
      $display("FAIL multi_cross: done=%0b cnt=%0d expected 1,21", done, msg_cnt);
    end
    checks++;
    if (up !== {3'd1, 3'd2} || down !== {3'd6, 3'd2} || left !== {3'd3, 3'd1} || right !== {3'd3, 3'd4}) begin
      errors++;
      $display("FAIL multi_anchors: up=%0d down=%0d left=%0d right=%0d expected 10,50,25,28", up, down, left, right);
    end
  endtask

  task automatic test_timeout();
    pulse_start();
    send_one(3, 1, 3, 2, 4);
    repeat (7) step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pre: done=%0b busy=%0b expected 0,1", done, busy);
    end
    step();
`ifdef BORDER_TIMEOUT_EN
    checks++;
    if (done !== 1'b1 || timed_out !== 1'b1 || msg_cnt !== 6'd1) begin
      errors++;
      $display("FAIL timeout_done: done=%0b tmo=%0b cnt=%0d expected 1,1,1", done, timed_out, msg_cnt);
    end
    checks++;
    if (up !== 6'd25 || down !== 6'd33 || left !== 6'd25 || right !== 6'd26) begin
      errors++;
      $display("FAIL timeout_anchors: up=%0d down=%0d left=%0d right=%0d expected 25,33,25,26", up, down, left, right);
    end
`else
    repeat (4) step();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || timed_out !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout: busy=%0b done=%0b tmo=%0b expected 1,0,0", busy, done, timed_out);
    end
`endif
    check_box("timeout_box", 1, 3, 2, 4);
  endtask

  initial begin
    test_reset();
    test_start_idle();
    test_merge_two();
    test_threshold();
    test_done_hold();
    test_clear();
    test_restart();
    test_multi_cross();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
